lwc_pdi_sender: RTL and testbench

LWC_PDI_SENDER -- requirements
Module: lwc_pdi_sender

---
 rtl/lwc_pdi_sender.sv | 232 +++++++++++++++++++++++
 tb/tb_lwc_pdi_sender.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lwc_pdi_sender.sv
// lwc_pdi_sender
// Formats one LWC command into a public-data-input word stream: an
// instruction word, then header + data segments for the nonce, the
// associated data, the message and, for decryption, the tag.
// Payload words come from the src stream and pass straight through
// (combinationally) during the data segments.
//
// Handshake rule on every stream (cmd, src, pdi): a word is transferred
// in a cycle where valid && ready are both high at the rising clock edge.
// A producer does not change data while valid is high and ready is low.
//
// Optional feature: define LWC_PDI_ZERO_PAD_EN to zero the unused
// trailing bytes of the final partial AD/MSG word (valid bytes are
// MSB-aligned). Without it, src_data passes through unmodified.
//
// fsm_state exposes the current state encoding for observation.

module lwc_pdi_sender #(
    parameter int BUSW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_decrypt,
    input  logic [15:0]     ad_len,
    input  logic [15:0]     msg_len,
    input  logic [BUSW-1:0] src_data,
    input  logic            src_valid,
    output logic            src_ready,
    output logic [BUSW-1:0] pdi_data,
    output logic            pdi_valid,
    input  logic            pdi_ready,
    output logic            done,
    output logic [3:0]      fsm_state
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_INST     = 4'd1;
    localparam logic [3:0] S_NPUB_HDR = 4'd2;
    localparam logic [3:0] S_NPUB_DAT = 4'd3;
    localparam logic [3:0] S_AD_HDR   = 4'd4;
    localparam logic [3:0] S_AD_DAT   = 4'd5;
    localparam logic [3:0] S_MSG_HDR  = 4'd6;
    localparam logic [3:0] S_MSG_DAT  = 4'd7;
    localparam logic [3:0] S_TAG_HDR  = 4'd8;
    localparam logic [3:0] S_TAG_DAT  = 4'd9;

    logic [3:0]  state;
    logic        dec_r;
    logic [15:0] ad_len_r;
    logic [15:0] msg_len_r;
    logic [14:0] cnt;          // words still to transfer in the current DAT state

    logic [16:0] ad_sum;
    logic [16:0] msg_sum;
    logic [14:0] ad_words;
    logic [14:0] msg_words;
    logic        hs;
    logic        last_word;
    logic        in_dat;
    logic [31:0] dat_word;

    // Header word: type, reserved bit, EOI, EOT, Last, reserved byte, length.
    function automatic logic [31:0] hdr(input logic [3:0] t, input logic eoi,
                                        input logic eot, input logic last,
                                        input logic [15:0] len);
        return {t, 1'b0, eoi, eot, last, 8'h00, len};
    endfunction

    // Word counts are computed in 17 bits so len=16'hFFFF yields 16384.
    always_comb begin
        ad_sum    = {1'b0, ad_len_r} + 17'd3;
        msg_sum   = {1'b0, msg_len_r} + 17'd3;
        ad_words  = ad_sum[16:2];
        msg_words = msg_sum[16:2];
    end

    assign hs        = pdi_valid && pdi_ready;
    assign last_word = (cnt == 15'd1);
    assign in_dat    = (state == S_NPUB_DAT) || (state == S_AD_DAT) ||
                       (state == S_MSG_DAT)  || (state == S_TAG_DAT);
    assign cmd_ready = (state == S_IDLE);
    assign fsm_state = state;

`ifdef LWC_PDI_ZERO_PAD_EN
    logic [1:0]  pad_len;
    logic [31:0] pad_mask;

    // Mask off trailing bytes of the final partial AD/MSG word.
    always_comb begin
        pad_len  = (state == S_AD_DAT) ? ad_len_r[1:0] : msg_len_r[1:0];
        pad_mask = 32'hFFFF_FFFF;
        if (((state == S_AD_DAT) || (state == S_MSG_DAT)) && last_word) begin
            case (pad_len)
                2'd1:    pad_mask = 32'hFF00_0000;
                2'd2:    pad_mask = 32'hFFFF_0000;
                2'd3:    pad_mask = 32'hFFFF_FF00;
                default: pad_mask = 32'hFFFF_FFFF;
            endcase
        end
        dat_word = src_data & pad_mask;
    end
`else
    assign dat_word = src_data;
`endif

    // Output mux: instruction/header words are held from registered state,
    // data states forward the src stream combinationally.
    always_comb begin
        pdi_valid = 1'b0;
        pdi_data  = '0;
        src_ready = 1'b0;
        case (state)
            S_INST: begin
                pdi_valid = 1'b1;
                pdi_data  = {3'b001, dec_r, 28'h0};
            end
            S_NPUB_HDR: begin
                pdi_valid = 1'b1;
                pdi_data  = hdr(4'hD, (ad_len_r == 16'd0) && (msg_len_r == 16'd0),
                                1'b1, 1'b0, 16'd16);
            end
            S_AD_HDR: begin
                pdi_valid = 1'b1;
                pdi_data  = hdr(4'h1, msg_len_r == 16'd0, 1'b1, 1'b0, ad_len_r);
            end
            S_MSG_HDR: begin
                pdi_valid = 1'b1;
                pdi_data  = hdr(dec_r ? 4'h5 : 4'h4, 1'b1, 1'b1, !dec_r, msg_len_r);
            end
            S_TAG_HDR: begin
                pdi_valid = 1'b1;
                pdi_data  = hdr(4'h8, 1'b1, 1'b1, 1'b1, 16'd16);
            end
            default: begin
                if (in_dat) begin
                    pdi_valid = src_valid;
                    pdi_data  = dat_word;
                    src_ready = pdi_ready;
                end
            end
        endcase
    end

    // done marks acceptance of the final word of the command.
    always_comb begin
        done = 1'b0;
        if (hs) begin
            if ((state == S_MSG_HDR) && !dec_r && (msg_words == 15'd0))
                done = 1'b1;
            else if ((state == S_MSG_DAT) && !dec_r && last_word)
                done = 1'b1;
            else if ((state == S_TAG_DAT) && last_word)
                done = 1'b1;
        end
    end

    // Command sequencer; reset overrides any handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            dec_r     <= 1'b0;
            ad_len_r  <= 16'd0;
            msg_len_r <= 16'd0;
            cnt       <= 15'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        dec_r     <= cmd_decrypt;
                        ad_len_r  <= ad_len;
                        msg_len_r <= msg_len;
                        state     <= S_INST;
                    end
                end
                S_INST: if (hs) state <= S_NPUB_HDR;
                S_NPUB_HDR: begin
                    if (hs) begin
                        cnt   <= 15'd4;
                        state <= S_NPUB_DAT;
                    end
                end
                S_NPUB_DAT: begin
                    if (hs) begin
                        cnt <= cnt - 15'd1;
                        if (last_word) state <= S_AD_HDR;
                    end
                end
                S_AD_HDR: begin
                    if (hs) begin
                        cnt   <= ad_words;
                        state <= (ad_words == 15'd0) ? S_MSG_HDR : S_AD_DAT;
                    end
                end
                S_AD_DAT: begin
                    if (hs) begin
                        cnt <= cnt - 15'd1;
                        if (last_word) state <= S_MSG_HDR;
                    end
                end
                S_MSG_HDR: begin
                    if (hs) begin
                        cnt <= msg_words;
                        if (msg_words != 15'd0) state <= S_MSG_DAT;
                        else                    state <= dec_r ? S_TAG_HDR : S_IDLE;
                    end
                end
                S_MSG_DAT: begin
                    if (hs) begin
                        cnt <= cnt - 15'd1;
                        if (last_word) state <= dec_r ? S_TAG_HDR : S_IDLE;
                    end
                end
                S_TAG_HDR: begin
                    if (hs) begin
                        cnt   <= 15'd4;
                        state <= S_TAG_DAT;
                    end
                end
                S_TAG_DAT: begin
                    if (hs) begin
                        cnt <= cnt - 15'd1;
                        if (last_word) state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lwc_pdi_sender.sv
// Bench for lwc_pdi_sender: table of commands with hand-computed PDI word
// sequences, plus reset and abort sequences.
module tb_lwc_pdi_sender;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_decrypt;
    logic [15:0] ad_len;
    logic [15:0] msg_len;
    logic [31:0] src_data;
    logic        src_valid;
    logic        src_ready;
    logic [31:0] pdi_data;
    logic        pdi_valid;
    logic        pdi_ready;
    logic        done;
    logic [3:0]  fsm_state;

    lwc_pdi_sender #(.BUSW(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_decrypt (cmd_decrypt),
        .ad_len      (ad_len),
        .msg_len     (msg_len),
        .src_data    (src_data),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .pdi_data    (pdi_data),
        .pdi_valid   (pdi_valid),
        .pdi_ready   (pdi_ready),
        .done        (done),
        .fsm_state   (fsm_state)
    );

    // Clock
    always #5 clk = ~clk;

`ifdef LWC_PDI_ZERO_PAD_EN
    localparam logic [31:0] AD_LAST_EXP = 32'hAA00_0000;
    localparam logic [31:0] V4_LAST_EXP = 32'h1234_0000;
    localparam logic [31:0] V5_LAST_EXP = 32'hCAFE_BA00;
`else
    localparam logic [31:0] AD_LAST_EXP = 32'hAABB_CCDD;
    localparam logic [31:0] V4_LAST_EXP = 32'h1234_5678;
    localparam logic [31:0] V5_LAST_EXP = 32'hCAFE_BABE;
`endif

    typedef struct packed {
        logic              dec;
        logic [15:0]       ad_len;
        logic [15:0]       msg_len;
        logic              rnd;
        logic [4:0]        src_n;
        logic [4:0]        exp_n;
        logic [15:0][31:0] src;
        logic [15:0][31:0] exp;
    } vec_t;

    localparam int NVEC = 6;
    vec_t vecs [NVEC];

    int checks_total  = 0;
    int checks_passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    task automatic set_cmd(input int v, input logic dec, input logic [15:0] al,
                           input logic [15:0] ml, input logic rnd);
        vecs[v]         = '0;
        vecs[v].dec     = dec;
        vecs[v].ad_len  = al;
        vecs[v].msg_len = ml;
        vecs[v].rnd     = rnd;
    endtask

    task automatic push_src(input int v, input logic [31:0] w);
        vecs[v].src[vecs[v].src_n] = w;
        vecs[v].src_n = vecs[v].src_n + 5'd1;
    endtask

    task automatic push_exp(input int v, input logic [31:0] w);
        vecs[v].exp[vecs[v].exp_n] = w;
        vecs[v].exp_n = vecs[v].exp_n + 5'd1;
    endtask

    // Nonce words go both into the source stream and the expected stream.
    task automatic push_nonce(input int v);
        for (int i = 1; i <= 4; i++) push_src(v, 32'h4E00_0000 + 32'(i));
    endtask
    task automatic exp_nonce(input int v);
        for (int i = 1; i <= 4; i++) push_exp(v, 32'h4E00_0000 + 32'(i));
    endtask
    task automatic push_tag(input int v);
        for (int i = 1; i <= 4; i++) push_src(v, 32'h7A00_0000 + 32'(i));
    endtask
    task automatic exp_tag(input int v);
        for (int i = 1; i <= 4; i++) push_exp(v, 32'h7A00_0000 + 32'(i));
    endtask

    task automatic fill_enc_5_8(input int v, input logic rnd);
        set_cmd(v, 1'b0, 16'd5, 16'd8, rnd);
        push_nonce(v);
        push_src(v, 32'h1111_1111); push_src(v, 32'hAABB_CCDD);
        push_src(v, 32'h3333_3333); push_src(v, 32'h4444_4444);
        push_exp(v, 32'h2000_0000); push_exp(v, 32'hD200_0010); exp_nonce(v);
        push_exp(v, 32'h1200_0005); push_exp(v, 32'h1111_1111); push_exp(v, AD_LAST_EXP);
        push_exp(v, 32'h4700_0008); push_exp(v, 32'h3333_3333); push_exp(v, 32'h4444_4444);
    endtask

    // Drive one command; compare every accepted PDI word, done, and held data.
    // With abort_after > 0 the run stops after that many accepted words.
    task automatic run_vec(input int vi, input int abort_after);
        vec_t        v;
        int          si;
        int          gi;
        int          target;
        logic        held_v;
        logic [31:0] held_d;
        logic        cmd_pend;
        v        = vecs[vi];
        si       = 0;
        gi       = 0;
        held_v   = 1'b0;
        held_d   = '0;
        cmd_pend = 1'b1;
        target   = (abort_after > 0) ? abort_after : int'(v.exp_n);
        for (int cyc = 0; cyc < 400 && gi < target; cyc++) begin
            @(negedge clk);
            cmd_valid   = cmd_pend;
            cmd_decrypt = v.dec;
            ad_len      = v.ad_len;
            msg_len     = v.msg_len;
            src_valid   = (si < int'(v.src_n));
            src_data    = src_valid ? v.src[si] : 32'h0;
            pdi_ready   = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (held_v) begin
                chk($sformatf("v%0d_hold_valid", vi), {31'b0, pdi_valid}, 32'd1);
                chk($sformatf("v%0d_hold_data", vi), pdi_data, held_d);
            end
            held_v = pdi_valid && !pdi_ready;
            held_d = pdi_data;
            if (cmd_valid && cmd_ready) cmd_pend = 1'b0;
            if (src_valid && src_ready) si++;
            if (pdi_valid && pdi_ready) begin
                chk($sformatf("v%0d_word%0d", vi, gi), pdi_data, v.exp[gi]);
                chk($sformatf("v%0d_done%0d", vi, gi), {31'b0, done},
                    {31'b0, (gi == int'(v.exp_n) - 1)});
                gi++;
            end else begin
                chk($sformatf("v%0d_stray_done", vi), {31'b0, done}, 32'd0);
            end
        end
        chk($sformatf("v%0d_word_count", vi), 32'(gi), 32'(target));
    endtask

    initial begin
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_decrypt = 1'b0;
        ad_len      = '0;
        msg_len     = '0;
        src_data    = '0;
        src_valid   = 1'b0;
        pdi_ready   = 1'b0;

        // Vector table
        fill_enc_5_8(0, 1'b0);

        set_cmd(1, 1'b1, 16'd0, 16'd0, 1'b0);
        push_nonce(1); push_tag(1);
        push_exp(1, 32'h3000_0000); push_exp(1, 32'hD600_0010); exp_nonce(1);
        push_exp(1, 32'h1600_0000); push_exp(1, 32'h5600_0000);
        push_exp(1, 32'h8700_0010); exp_tag(1);

        fill_enc_5_8(2, 1'b1);

        set_cmd(3, 1'b0, 16'd0, 16'd0, 1'b0);
        push_nonce(3);
        push_exp(3, 32'h2000_0000); push_exp(3, 32'hD600_0010); exp_nonce(3);
        push_exp(3, 32'h1600_0000); push_exp(3, 32'h4700_0000);

        set_cmd(4, 1'b1, 16'd4, 16'd6, 1'b1);
        push_nonce(4);
        push_src(4, 32'h0BAD_F00D); push_src(4, 32'h5555_5555); push_src(4, 32'h1234_5678);
        push_tag(4);
        push_exp(4, 32'h3000_0000); push_exp(4, 32'hD200_0010); exp_nonce(4);
        push_exp(4, 32'h1200_0004); push_exp(4, 32'h0BAD_F00D);
        push_exp(4, 32'h5600_0006); push_exp(4, 32'h5555_5555); push_exp(4, V4_LAST_EXP);
        push_exp(4, 32'h8700_0010); exp_tag(4);

        set_cmd(5, 1'b0, 16'd0, 16'd3, 1'b0);
        push_nonce(5); push_src(5, 32'hCAFE_BABE);
        push_exp(5, 32'h2000_0000); push_exp(5, 32'hD200_0010); exp_nonce(5);
        push_exp(5, 32'h1200_0000); push_exp(5, 32'h4700_0003); push_exp(5, V5_LAST_EXP);

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_pdi_valid", {31'b0, pdi_valid}, 32'd0);
        chk("rst_src_ready", {31'b0, src_ready}, 32'd0);
        chk("rst_done",      {31'b0, done},      32'd0);
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("rst_pdi_data",  pdi_data,           32'd0);

        // Table-driven commands
        for (int i = 0; i < NVEC; i++) begin
            run_vec(i, 0);
            @(negedge clk);
            cmd_valid = 1'b0;
            src_valid = 1'b0;
            #1;
            chk($sformatf("v%0d_idle_after", i), {31'b0, cmd_ready}, 32'd1);
        end

        // Abort during AD data: 7 words reach the first AD data word
        run_vec(0, 7);
        @(negedge clk);
        #1;
        chk("abort_in_ad_dat", {28'b0, fsm_state}, 32'd5);
        @(negedge clk);
        rst       = 1'b1;
        cmd_valid = 1'b0;
        src_valid = 1'b1;
        pdi_ready = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        src_valid = 1'b0;
        #1;
        chk("abort_pdi_valid", {31'b0, pdi_valid}, 32'd0);
        chk("abort_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("abort_done",      {31'b0, done},      32'd0);
        run_vec(0, 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        src_valid = 1'b0;
        #1;
        chk("post_abort_idle", {31'b0, cmd_ready}, 32'd1);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
